// File: rtl/gate_bist_ctrl_pkg.sv
// Shared definitions for the gate-unit self-test sequencer.
// Contents: output bit positions, FSM state encoding and the golden truth table.
// Pure declarations: no logic, no latency, no flow control.
package gate_bist_pkg;

   // Bit positions of the gate-unit outputs on y_in.
   localparam int unsigned Y_AND  = 0;
   localparam int unsigned Y_OR   = 1;
   localparam int unsigned Y_NOT  = 2;
   localparam int unsigned Y_NAND = 3;
   localparam int unsigned Y_NOR  = 4;
   localparam int unsigned Y_XOR  = 5;
   localparam int unsigned Y_XNOR = 6;

   localparam int unsigned Y_W = 7;

   // Sequencer states; the FSM stores these in a plain 2-bit register.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2
   } state_e;

   // Expected gate-unit outputs for a given input pair.
   function automatic logic [Y_W-1:0] golden(input logic a, input logic b);
      logic [Y_W-1:0] y;
      y         = '0;
      y[Y_AND]  = a & b;
      y[Y_OR]   = a | b;
      y[Y_NOT]  = ~a;
      y[Y_NAND] = ~(a & b);
      y[Y_NOR]  = ~(a | b);
      y[Y_XOR]  = a ^ b;
      y[Y_XNOR] = ~(a ^ b);
      return y;
   endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Host + gate-unit side bundle for the self-test sequencer.
// Latency: none, wires only.
// Backpressure: none; start is a level request honoured only when idle.
interface gate_bist_ctrl_if;
   import gate_bist_pkg::*;

   logic                 start;
   logic                 abort;
   logic                 a;
   logic                 b;
   logic [Y_W-1:0]       y_in;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [3:0]           err_count;
   logic [1:0]           fail_vec;
   logic [Y_W-1:0]       fail_mask;

   // Sequencer side.
   modport slave (
      input  start, abort, y_in,
      output a, b, busy, done, pass, err_count, fail_vec, fail_mask
   );

   // Host / gate-unit side.
   modport master (
      output start, abort, y_in,
      input  a, b, busy, done, pass, err_count, fail_vec, fail_mask
   );

endinterface

// File: rtl/gate_bist_ctrl.sv
// Sweeps the gate unit through all four input vectors, PASSES times, checking outputs against golden.
// Latency: done pulses 4*PASSES*(SETTLE_CYCLES+1) cycles after the accepting start edge.
// Backpressure: start ignored while busy; abort cancels a run and returns to idle next edge.
module gate_bist_ctrl
   import gate_bist_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,   // 1..15
   parameter int unsigned PASSES        = 1    // 1..15
) (
   input  logic              clk,
   input  logic              rst_n,
   gate_bist_ctrl_if.slave   bus
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_SETTLE = ST_SETTLE;
   localparam logic [1:0] S_CHECK  = ST_CHECK;

   localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] LAST_PASS     = 4'(PASSES - 1);
   localparam logic [3:0] ERR_MAX       = 4'd15;

   logic [1:0]     state_q,     state_d;
   logic [1:0]     v_q,         v_d;          // current vector, {a,b}
   logic [3:0]     cnt_q,       cnt_d;        // settle countdown
   logic [3:0]     pass_cnt_q,  pass_cnt_d;
   logic           busy_q,      busy_d;
   logic           done_q,      done_d;
   logic           pass_q,      pass_d;
   logic [3:0]     err_q,       err_d;
   logic [1:0]     fail_vec_q,  fail_vec_d;
   logic [Y_W-1:0] fail_mask_q, fail_mask_d;

   logic [Y_W-1:0] exp_y;
   logic [Y_W-1:0] diff;
   logic           mism;
   logic           last_check;

   // The vector register is also the gate-unit drive; it is parked at 00 whenever idle.
   assign exp_y      = golden(v_q[1], v_q[0]);
   assign diff       = exp_y ^ bus.y_in;
   assign mism       = |diff;
   assign last_check = (v_q == 2'd3) && (pass_cnt_q == LAST_PASS);

   // Next-state logic for the sweep FSM, counters and result registers.
   always_comb begin
      state_d     = state_q;
      v_d         = v_q;
      cnt_d       = cnt_q;
      pass_cnt_d  = pass_cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      err_d       = err_q;
      fail_vec_d  = fail_vec_q;
      fail_mask_d = fail_mask_q;

      case (state_q)
         S_IDLE: begin
            // abort wins over a simultaneous start and leaves everything untouched
            if (bus.start && !bus.abort) begin
               v_d         = 2'd0;
               cnt_d       = SETTLE_RELOAD;
               pass_cnt_d  = 4'd0;
               err_d       = 4'd0;
               fail_vec_d  = 2'd0;
               fail_mask_d = '0;
               pass_d      = 1'b0;
               busy_d      = 1'b1;
               state_d     = S_SETTLE;
            end
         end

         S_SETTLE: begin
            if (bus.abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               pass_d  = 1'b0;
               v_d     = 2'd0;
            end else if (cnt_q == 4'd0) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         S_CHECK: begin
            if (bus.abort) begin
               // partial error results are kept; the aborted check is not scored
               state_d = S_IDLE;
               busy_d  = 1'b0;
               pass_d  = 1'b0;
               v_d     = 2'd0;
            end else begin
               if (mism) begin
                  if (err_q != ERR_MAX) begin
                     err_d = err_q + 4'd1;
                  end
                  // err_q is zero exactly until the run's first failure
                  if (err_q == 4'd0) begin
                     fail_vec_d  = v_q;
                     fail_mask_d = diff;
                  end
               end

               if (last_check) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 4'd0);
                  v_d     = 2'd0;
               end else begin
                  if (v_q == 2'd3) begin
                     pass_cnt_d = pass_cnt_q + 4'd1;
                  end
                  v_d     = v_q + 2'd1;
                  cnt_d   = SETTLE_RELOAD;
                  state_d = S_SETTLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            v_d     = 2'd0;
         end
      endcase
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         v_q         <= 2'd0;
         cnt_q       <= 4'd0;
         pass_cnt_q  <= 4'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= 4'd0;
         fail_vec_q  <= 2'd0;
         fail_mask_q <= '0;
      end else begin
         state_q     <= state_d;
         v_q         <= v_d;
         cnt_q       <= cnt_d;
         pass_cnt_q  <= pass_cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_q       <= err_d;
         fail_vec_q  <= fail_vec_d;
         fail_mask_q <= fail_mask_d;
      end
   end

   assign bus.a         = v_q[1];
   assign bus.b         = v_q[0];
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.fail_vec  = fail_vec_q;
   assign bus.fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: three instances (P=1/S=2, P=4/S=2, P=8/S=1) each driving a faultable gate model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_gate_bist_ctrl;

   logic clk;
   logic rst_n;

   logic        st [3];
   logic        ab [3];
   logic [6:0]  fz [3];   // outputs forced to 0
   logic [6:0]  fo [3];   // outputs forced to 1
   logic [17:0] obs_v [3];

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent truth table of the gate unit.
   function automatic logic [6:0] gate_model(input logic ia, input logic ib);
      logic [6:0] y;
      y = {~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ~ia, ia | ib, ia & ib};
      return y;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      gate_bist_ctrl_if bus ();
      gate_bist_ctrl #(
         .SETTLE_CYCLES((g == 2) ? 1 : 2),
         .PASSES       ((g == 0) ? 1 : ((g == 1) ? 4 : 8))
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
      assign bus.start = st[g];
      assign bus.abort = ab[g];
      assign bus.y_in  = (gate_model(bus.a, bus.b) & ~fz[g]) | fo[g];
      assign obs_v[g]  = {bus.a, bus.b, bus.busy, bus.done, bus.pass,
                          bus.err_count, bus.fail_vec, bus.fail_mask};
   end

   function automatic int sc_of(input int d);
      return (d == 2) ? 1 : 2;
   endfunction

   function automatic int ps_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
   endfunction

   function automatic int n_of(input int d);
      return 4 * ps_of(d) * (sc_of(d) + 1);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, expv);
      end
   endtask

   // Whole-run result from the fault masks: every pass visits 00,01,10,11.
   task automatic model_run(input int p, input logic [6:0] mz, input logic [6:0] mo,
                            output int ec, output logic [1:0] fv, output logic [6:0] fm);
      logic [6:0] ideal;
      logic [6:0] seen;
      ec = 0;
      fv = 2'd0;
      fm = 7'd0;
      for (int i = 0; i < p; i++) begin
         for (int v = 0; v < 4; v++) begin
            ideal = gate_model(v >= 2, (v % 2) == 1);
            seen  = (ideal & ~mz) | mo;
            if (seen != ideal) begin
               if (ec == 0) begin
                  fv = 2'(v);
                  fm = ideal ^ seen;
               end
               if (ec < 15) ec++;
            end
         end
      end
   endtask

   // One full run on instance d; mid > 0 re-pulses start before edge mid.
   task automatic run_sweep(input int d, input int mid);
      int         s;
      int         n;
      int         v;
      int         e_err;
      logic [1:0] e_fv;
      logic [6:0] e_fm;
      logic [3:0] ctl;
      s = sc_of(d);
      n = n_of(d);
      model_run(ps_of(d), fz[d], fo[d], e_err, e_fv, e_fm);

      @(negedge clk);
      st[d] = 1'b1;
      @(posedge clk);
      #1;
      st[d] = 1'b0;
      check_val("start_state", {obs_v[d][15], obs_v[d][14], obs_v[d][17], obs_v[d][16]}, 4'b1000);
      for (int k = 1; k <= n; k++) begin
         if (k == mid) st[d] = 1'b1;
         @(posedge clk);
         #1;
         st[d] = 1'b0;
         ctl = {obs_v[d][15], obs_v[d][14], obs_v[d][17], obs_v[d][16]};
         if (k < n) begin
            v = (k / (s + 1)) % 4;
            check_val("sweep_busy_done_ab", ctl, {2'b10, v[1], v[0]});
         end else begin
            check_val("done_edge", ctl, 4'b0100);
            check_val("res_err", obs_v[d][12:9], e_err);
            check_val("res_fail_vec", obs_v[d][8:7], e_fv);
            check_val("res_fail_mask", obs_v[d][6:0], e_fm);
            check_val("res_pass", obs_v[d][13], e_err == 0);
         end
      end
      @(posedge clk);
      #1;
      check_val("done_pulse_len", {obs_v[d][15], obs_v[d][14]}, 2'b00);
      check_val("pass_held", obs_v[d][13], e_err == 0);
   endtask

   initial begin
      int d;
      int dones;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0;
         ab[i] = 1'b0;
         fz[i] = 7'd0;
         fo[i] = 7'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) check_val("reset_outputs", obs_v[i], 18'd0);
      rst_n = 1'b1;

      // clean sweep, defaults
      run_sweep(0, 0);

      // NOT output stuck at 0
      fz[0] = 7'b0000100;
      run_sweep(0, 0);

      // XOR stuck at 1, 4 passes and 8 passes (saturation)
      fo[1] = 7'b0100000;
      run_sweep(1, 0);
      fo[2] = 7'b0100000;
      run_sweep(2, 0);

      // start re-pulsed mid-run
      fz[0] = 7'd0;
      run_sweep(0, 5);

      // abort during SETTLE of vector 2, with NOT stuck at 0
      fz[0] = 7'b0000100;
      @(negedge clk);
      st[0] = 1'b1;
      @(posedge clk);
      #1;
      st[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check_val("pre_abort_ab", {obs_v[0][17], obs_v[0][16]}, 2'b10);
      ab[0] = 1'b1;
      @(posedge clk);
      #1;
      ab[0] = 1'b0;
      check_val("abort_busy_done_ab_pass", obs_v[0][17:13], 5'd0);
      check_val("abort_err_hold", obs_v[0][12:9], 4'd2);
      check_val("abort_fail_hold", {obs_v[0][8:7], obs_v[0][6:0]}, {2'd0, 7'b0000100});
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (obs_v[0][14] || obs_v[0][15]) dones++;
      end
      check_val("abort_quiet", dones, 0);
      fz[0] = 7'd0;
      run_sweep(0, 0);

      // start and abort together while idle
      @(negedge clk);
      st[0] = 1'b1;
      ab[0] = 1'b1;
      @(posedge clk);
      #1;
      st[0] = 1'b0;
      ab[0] = 1'b0;
      check_val("start_abort_idle", obs_v[0][15], 1'b0);

      // reset during CHECK of vector 0
      fz[0] = 7'b0000001;
      @(negedge clk);
      st[0] = 1'b1;
      @(posedge clk);
      #1;
      st[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) check_val("midrun_reset", obs_v[i], 18'd0);
      fz[0] = 7'd0;
      run_sweep(0, 0);

      // randomized fault patterns across instances
      for (int it = 0; it < 8; it++) begin
         d = $urandom_range(0, 2);
         if ($urandom_range(0, 3) == 0) begin
            fz[d] = 7'd0;
            fo[d] = 7'd0;
         end else begin
            fz[d] = 7'($urandom) & 7'($urandom);
            fo[d] = 7'($urandom) & 7'($urandom) & ~fz[d];
         end
         run_sweep(d, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n_of(d) - 1)) : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
